// File: rtl/booth_operand_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | booth_operand_seq: loads M then Q into the Booth multiplier, waits for a |
// | done rising edge (or timeout) and hands the product downstream. Rev 1.0   |
// +--------------------------------------------------------------------------+
module booth_operand_seq #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_multiplicand,
    input  logic [WIDTH-1:0]     in_multiplier,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_data,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 out_timeout,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_LD_M  = 3'd2,
        S_LD_Q  = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_q;
    logic [7:0]           r_cnt;
    logic                 r_done_q;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_timeout;
    logic                 w_rise;
    logic                 w_expire;

    assign w_rise      = mul_done & ~r_done_q;
    assign w_expire    = (r_cnt == C_CNT_LAST);
    assign out_product = r_product;
    assign out_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every output except in_ready's effect on acceptance is a pure state decode.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        mul_data  = '0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                mul_start = 1'b1;
                mul_data  = r_m;
                w_next    = S_LD_M;
            end
            S_LD_M: begin
                mul_data = r_m;
                w_next   = S_LD_Q;
            end
            S_LD_Q: begin
                mul_data = r_q;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                mul_data = r_q;
                if (w_rise || w_expire) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_m       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_done_q  <= 1'b0;
            r_product <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m <= in_multiplicand;
                        r_q <= in_multiplier;
                    end
                end
                S_LD_Q: begin
                    // Seeding done_q here masks a done level left high from the last operation.
                    r_cnt    <= '0;
                    r_done_q <= mul_done;
                end
                S_WAIT: begin
                    r_done_q <= mul_done;
                    r_cnt    <= r_cnt + 8'd1;
                    if (w_rise) begin
                        r_product <= mul_product;
                        r_timeout <= 1'b0;
                    end else if (w_expire) begin
                        r_product <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_operand_seq.sv
`default_nettype none
// Testbench for booth_operand_seq: table vectors, reset corner case and random
// operations checked against a behavioural sequencing/multiplier model.
module tb_booth_operand_seq;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_multiplicand;
    logic [7:0]  in_multiplier;
    logic        mul_start;
    logic [7:0]  mul_data;
    logic        mul_done;
    logic [15:0] mul_product;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_product;
    logic        out_timeout;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    booth_operand_seq #(.WIDTH(8), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .clr_n          (clr_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_multiplicand(in_multiplicand),
        .in_multiplier  (in_multiplier),
        .mul_start      (mul_start),
        .mul_data       (mul_data),
        .mul_done       (mul_done),
        .mul_product    (mul_product),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_product    (out_product),
        .out_timeout    (out_timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        int          d;
        bit          stale;
        int          hold;
        bit          offer;
        logic [15:0] xp;
        bit          xt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_mul(input logic [7:0] m, input logic [7:0] q);
        int pm;
        int pq;
        pm = $signed(m);
        pq = $signed(q);
        return 16'(pm * pq);
    endfunction

    // Cycles from WAIT entry until out_valid: done rising d WAIT cycles in, else the timeout.
    function automatic int model_lat(input int d, input bit stale);
        return (!stale && d <= TO - 1) ? d + 1 : TO;
    endfunction

    // Called positioned at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic do_op(input logic [7:0] m, input logic [7:0] q, input int d, input bit stale,
                         input int hold, input bit offer, input logic [7:0] nm, input logic [7:0] nq,
                         input logic [15:0] xp, input bit xt);
        int seen;
        int bad;
        logic [15:0] held;
        mul_done        = stale;
        mul_product     = 16'($urandom);
        in_multiplicand = m;
        in_multiplier   = q;
        in_valid        = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("start_pulse", mul_start, 1);
        check("data_m_first", mul_data, m);
        check("in_ready_busy", in_ready, 0);
        @(negedge clk);
        check("start_single", mul_start, 0);
        check("data_m_second", mul_data, m);
        @(negedge clk);
        check("data_q", mul_data, q);
        seen = -1;
        bad  = 0;
        for (int c = 0; c <= TO + 8 && seen < 0; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = c;
            end else begin
                if (mul_data !== q || busy !== 1'b1) bad++;
                if (c == d) begin
                    mul_done    = 1'b1;
                    mul_product = model_mul(m, q);
                end
            end
        end
        check("wait_data_errs", bad, 0);
        check("latency", seen, model_lat(d, stale));
        mul_product = 16'($urandom);
        check("product", out_product, xp);
        check("timeout_flag", out_timeout, xt);
        check("out_data_zero", mul_data, 0);
        held = out_product;
        if (offer) begin
            in_multiplicand = nm;
            in_multiplier   = nq;
            in_valid        = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_product", out_product, held);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_start", mul_start, 0);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{8'h07, 8'hFD, 20, 1'b0, 0,  1'b0, 16'hFFEB, 1'b0};
        tbl[1] = '{8'h80, 8'h80, 5,  1'b0, 1,  1'b0, 16'h4000, 1'b0};
        tbl[2] = '{8'h12, 8'h34, 0,  1'b0, 10, 1'b1, 16'h03A8, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 3,  1'b0, 2,  1'b0, 16'h0001, 1'b0};
        tbl[4] = '{8'h33, 8'h44, 7,  1'b1, 0,  1'b0, 16'h0000, 1'b1};
        tbl[5] = '{8'h01, 8'h01, 64, 1'b0, 0,  1'b0, 16'h0000, 1'b1};
        tbl[6] = '{8'h7F, 8'h7F, 63, 1'b0, 0,  1'b0, 16'h3F01, 1'b0};

        clr_n           = 1'b0;
        in_valid        = 1'b0;
        in_multiplicand = '0;
        in_multiplier   = '0;
        mul_done        = 1'b0;
        mul_product     = '0;
        out_ready       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_start", mul_start, 0);
        check("rst_data", mul_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_product", out_product, 0);
        check("rst_timeout", out_timeout, 0);
        check("rst_busy", busy, 0);
        clr_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].m, tbl[i].q, tbl[i].d, tbl[i].stale, tbl[i].hold, tbl[i].offer,
                  tbl[(i + 1) % 7].m, tbl[(i + 1) % 7].q, tbl[i].xp, tbl[i].xt);
        end

        // Reset pulse while waiting on the multiplier.
        mul_done        = 1'b0;
        in_multiplicand = 8'h09;
        in_multiplier   = 8'h0A;
        in_valid        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_busy", busy, 1);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        check("mrst_in_ready", in_ready, 1);
        check("mrst_start", mul_start, 0);
        check("mrst_data", mul_data, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_product", out_product, 0);
        check("mrst_timeout", out_timeout, 0);
        check("mrst_busy", busy, 0);
        do_op(8'h05, 8'h06, 10, 1'b0, 0, 1'b0, 8'h00, 8'h00, 16'h001E, 1'b0);

        for (int r = 0; r < 24; r++) begin
            logic [7:0] m;
            logic [7:0] q;
            int         d;
            bit         st;
            bit         to;
            m  = 8'($urandom);
            q  = 8'($urandom);
            d  = $urandom_range(0, 70);
            st = ($urandom_range(0, 7) == 0);
            to = st || (d > TO - 1);
            do_op(m, q, d, st, $urandom_range(0, 3), 1'b0, 8'h00, 8'h00,
                  to ? 16'h0000 : model_mul(m, q), to);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_operand_seq.md
# booth_operand_seq

Upstream sequencer for the 8-bit Booth multiplier datapath. It accepts a multiplicand/multiplier pair over a valid/ready handshake and drives the multiplier's `start` and shared `data_in` bus in the order that datapath loads them: multiplicand first, then multiplier. It then waits for the multiplier's `done` and presents the 16-bit signed product downstream over a second valid/ready handshake. A timeout stops a stalled multiplier from hanging the pipeline.

## Interface
- `WIDTH`, default 8: operand width; the product is 2*WIDTH bits.
- `TIMEOUT`, default 64: WAIT-state cycles allowed before the result is declared timed out. Range 1..255.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `clr_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept a pair.
- `in_multiplicand` in WIDTH: signed multiplicand (M).
- `in_multiplier` in WIDTH: signed multiplier (Q).
- `mul_start` out 1: start strobe to the multiplier.
- `mul_data` out WIDTH: shared operand bus to the multiplier's `data_in`.
- `mul_done` in 1: level done from the multiplier.
- `mul_product` in 2*WIDTH: multiplier product, {A,Q}.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_product` out 2*WIDTH: registered product.
- `out_timeout` out 1: result is a timeout, qualified by `out_valid`.
- `busy` out 1: high in every state except IDLE.

## Operation
- State machine: IDLE, START, LD_M, LD_Q, WAIT, OUT.
- IDLE
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, register both operands and go to START.
- START: `mul_start`=1 for exactly one cycle; `mul_data`=M; go to LD_M.
- LD_M: `mul_data`=M; go to LD_Q.
- LD_Q
  - `mul_data`=Q.
  - Clear the timeout counter.
  - Register the current `mul_done` into `done_q`.
  - Go to WAIT.
- WAIT
  - `mul_data`=Q (held).
  - Each cycle: `done_q`<=`mul_done`; the counter increments.
  - Rising edge (`mul_done`=1 and `done_q`=0): capture `mul_product` into `out_product`, set `out_timeout`=0, go to OUT.
  - Otherwise, if the counter equals TIMEOUT-1: set `out_product`=0 and `out_timeout`=1, go to OUT.
  - A rising edge and a timeout in the same cycle resolve as a rising edge (valid product).
  - A `mul_done` level that is already high on entry is ignored. This covers a stale done left over from the previous operation.
- OUT
  - `out_valid`=1; `out_product` and `out_timeout` held stable.
  - On `out_ready`=1, go to IDLE.
- `mul_data`=0 in IDLE and OUT.
- `in_ready`=0 outside IDLE. `in_valid` while busy is not consumed; the operands are held by the source.
- Operand and product registers are plain bit copies. No sign extension or arithmetic happens inside this block.

## Timing
- Reset
  - `clr_n`=0 at a rising edge forces IDLE in any state, including mid-operation.
  - Reset values: `mul_start`=0, `mul_data`=0, `out_valid`=0, `out_product`=0, `out_timeout`=0, `busy`=0, counter=0, `done_q`=0.
  - `in_ready`=1 from the first cycle after reset is released.
- Accept at edge t:
  - `mul_start`=1 in cycle t+1.
  - `mul_data`=M in cycles t+1 and t+2.
  - `mul_data`=Q from cycle t+3 until OUT is entered.
- Rising edge of `mul_done` sampled at edge d: `out_valid`=1 from cycle d+1.
- Timeout: `out_valid` rises TIMEOUT cycles after WAIT is entered.
- Back-to-back operation: the earliest next accept is the cycle after the OUT handshake. `in_ready` is combinational from state.
- All outputs are registered or decoded from state. There is no combinational path from `in_valid` or `out_ready` to any output except `in_ready`.

## Test plan
- Basic product:
  - Stimulus: M=8'h07, Q=8'hFD (7 × -3); model raises `mul_done` 20 cycles after LD_Q, `mul_product`=16'hFFEB.
  - Response: `mul_start` is a single pulse; `mul_data`=07,07,FD on consecutive cycles; `out_product`=16'hFFEB; `out_timeout`=0.
- Extreme operands:
  - Stimulus: M=8'h80, Q=8'h80; model returns 16'h4000.
  - Response: `out_product`=16'h4000, with the product bits passed through unaltered.
- Backpressure and busy:
  - Stimulus: `out_ready`=0 for 10 cycles in OUT; meanwhile a second pair is offered.
  - Response: `out_valid` and `out_product` stay stable; `in_ready`=0 and the second pair is not accepted; it is accepted the cycle after `out_ready`=1.
- Stale done and timeout:
  - Stimulus: `mul_done` held high throughout, with TIMEOUT=64.
  - Response: no capture; `out_valid` rises 64 cycles after WAIT is entered, with `out_timeout`=1 and `out_product`=0.
- Same-cycle edge and timeout:
  - Stimulus: the `mul_done` rising edge arrives on the timeout cycle.
  - Response: the product is captured and `out_timeout`=0.
- Reset mid-operation:
  - Stimulus: `clr_n`=0 for 1 cycle during WAIT.
  - Response: next cycle IDLE with `in_ready`=1 and every output at its reset value; a fresh pair (M=8'h05, Q=8'h06, product 16'h001E) then completes normally.
